// File: rtl/tnn_sample_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tnn_seq_pkg
// Brief    : Shared types and default constants for the sample sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package tnn_seq_pkg;

    // Default geometry of the 2-bit-feature classifier front-end
    localparam int N_FEAT = 9;
    localparam int FEAT_W = 2;
    localparam int ACC_W  = 16;
    localparam int IDX_W  = $clog2(N_FEAT);

    // Sequencer control states
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        EVAL    = 2'd2,
        OUT     = 2'd3
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/tnn_sample_sequencer_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : tnn_sat_counter
// Brief    : Saturating up-counter with synchronous clear (clear has priority).
// Revision : 1.0 - initial release
// ============================================================================
module tnn_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    // Count up until all-ones, then hold; a clear overrides any increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/tnn_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tnn_sample_sequencer
// Brief    : Assembles 2-bit feature beats into a sample, drives the external
//            classifier, captures its decision and returns it as a result
//            stream while keeping saturating sample/positive statistics.
// Revision : 1.0 - initial release
// ============================================================================
module tnn_sample_sequencer
    import tnn_seq_pkg::*;
#(
    parameter int N_FEAT = tnn_seq_pkg::N_FEAT,
    parameter int FEAT_W = tnn_seq_pkg::FEAT_W,
    parameter int ACC_W  = tnn_seq_pkg::ACC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [FEAT_W-1:0]        s_data,
    input  logic                     s_last,
    output logic [N_FEAT*FEAT_W-1:0] feat_bus,
    input  logic                     cls_in,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_class,
    output logic                     err_len,
    input  logic                     clr_stats,
    output logic [ACC_W-1:0]         sample_count,
    output logic [ACC_W-1:0]         pos_count
);

    localparam int IW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N_FEAT - 1);

    seq_state_t                state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [N_FEAT*FEAT_W-1:0]  feat_q, feat_d;
    logic                      class_q, class_d;
    logic                      err_q, err_d;
    logic                      eval_w;

    // Handshake outputs depend on registered state only
    assign s_ready  = (state_q == COLLECT) || (state_q == DRAIN);
    assign m_valid  = (state_q == OUT);
    assign m_class  = class_q;
    assign err_len  = err_q;
    assign feat_bus = feat_q;
    assign eval_w   = (state_q == EVAL);

    // State, slot index, feature bus, decision and error pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            feat_q  <= '0;
            class_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            feat_q  <= feat_d;
            class_q <= class_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: sample assembly, length checking and result handshake
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        feat_d  = feat_q;
        class_d = class_q;
        err_d   = 1'b0;
        case (state_q)
            COLLECT: begin
                if (s_valid) begin
                    feat_d[int'(idx_q)*FEAT_W +: FEAT_W] = s_data;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        if (s_last) begin
                            state_d = EVAL;
                        end else begin
                            // Too long: flag now, swallow the rest of the sample
                            err_d   = 1'b1;
                            state_d = DRAIN;
                        end
                    end else if (s_last) begin
                        // Too short: flag and restart at slot 0
                        err_d = 1'b1;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            DRAIN: begin
                if (s_valid && s_last) begin
                    idx_d   = '0;
                    state_d = COLLECT;
                end
            end
            EVAL: begin
                class_d = cls_in;
                state_d = OUT;
            end
            OUT: begin
                if (m_ready) begin
                    idx_d   = '0;
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
                idx_d   = '0;
            end
        endcase
    end

    tnn_sat_counter #(.WIDTH(ACC_W)) u_sample_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (eval_w),
        .clr   (clr_stats),
        .count (sample_count)
    );

    tnn_sat_counter #(.WIDTH(ACC_W)) u_pos_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (eval_w & cls_in),
        .clr   (clr_stats),
        .count (pos_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_tnn_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tnn_sample_sequencer
// Brief    : Directed self-checking bench for tnn_sample_sequencer (ACC_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tnn_sample_sequencer;

    localparam int N_FEAT = 9;
    localparam int FEAT_W = 2;
    localparam int ACC_W  = 4;

    logic                     clk;
    logic                     rst_n;
    logic                     s_valid;
    logic                     s_ready;
    logic [FEAT_W-1:0]        s_data;
    logic                     s_last;
    logic [N_FEAT*FEAT_W-1:0] feat_bus;
    logic                     cls_in;
    logic                     m_valid;
    logic                     m_ready;
    logic                     m_class;
    logic                     err_len;
    logic                     clr_stats;
    logic [ACC_W-1:0]         sample_count;
    logic [ACC_W-1:0]         pos_count;

    int checks;
    int errors;

    tnn_sample_sequencer #(
        .N_FEAT (N_FEAT),
        .FEAT_W (FEAT_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .feat_bus     (feat_bus),
        .cls_in       (cls_in),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_class      (m_class),
        .err_len      (err_len),
        .clr_stats    (clr_stats),
        .sample_count (sample_count),
        .pos_count    (pos_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat presented for exactly one clock, sampled 1 time unit after the edge
    task automatic send_beat(input logic [1:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Nine well-formed beats; returns with the DUT in EVAL
    task automatic send_sample(input logic [17:0] v);
        for (int k = 0; k < N_FEAT; k++) begin
            send_beat(v[k*2 +: 2], k == N_FEAT - 1);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        s_last    = 1'b0;
        cls_in    = 1'b0;
        m_ready   = 1'b0;
        clr_stats = 1'b0;

        // ---- Reset state
        #22;
        rst_n = 1'b1;
        tick();
        check("rst_s_ready",  32'(s_ready), 32'h1);
        check("rst_m_valid",  32'(m_valid), 32'h0);
        check("rst_m_class",  32'(m_class), 32'h0);
        check("rst_err_len",  32'(err_len), 32'h0);
        check("rst_feat_bus", 32'(feat_bus), 32'h0);
        check("rst_samples",  32'(sample_count), 32'h0);
        check("rst_pos",      32'(pos_count), 32'h0);

        // ---- Nine beats of 3, classifier says 1
        cls_in  = 1'b1;
        m_ready = 1'b1;
        send_sample(18'h3FFFF);
        check("t1_feat_bus",     32'(feat_bus), 32'h3FFFF);
        check("t1_eval_m_valid", 32'(m_valid), 32'h0);
        check("t1_eval_s_ready", 32'(s_ready), 32'h0);
        tick();
        check("t1_m_valid", 32'(m_valid), 32'h1);
        check("t1_m_class", 32'(m_class), 32'h1);
        check("t1_samples", 32'(sample_count), 32'h1);
        check("t1_pos",     32'(pos_count), 32'h1);
        tick();
        check("t1_done_m_valid", 32'(m_valid), 32'h0);
        check("t1_done_s_ready", 32'(s_ready), 32'h1);

        // ---- Short sample: s_last on beat 4 (slots 0..3 = 1,2,3,0)
        send_beat(2'd1, 1'b0);
        send_beat(2'd2, 1'b0);
        send_beat(2'd3, 1'b0);
        send_beat(2'd0, 1'b1);
        check("t2_err_pulse", 32'(err_len), 32'h1);
        check("t2_feat_bus",  32'(feat_bus), 32'h3FF39);
        tick();
        check("t2_err_clear", 32'(err_len), 32'h0);
        check("t2_no_result", 32'(m_valid), 32'h0);
        // Next well-formed sample restarts at slot 0, classifier says 0
        cls_in = 1'b0;
        send_sample(18'h0E4E4);
        check("t2b_feat_bus", 32'(feat_bus), 32'h0E4E4);
        tick();
        check("t2b_m_valid", 32'(m_valid), 32'h1);
        check("t2b_m_class", 32'(m_class), 32'h0);
        check("t2b_samples", 32'(sample_count), 32'h2);
        check("t2b_pos",     32'(pos_count), 32'h1);
        tick();

        // ---- Long sample: twelve beats, s_last only on beat 12
        for (int k = 0; k < 8; k++) send_beat(2'd2, 1'b0);
        send_beat(2'd2, 1'b0);
        check("t3_err_pulse",   32'(err_len), 32'h1);
        check("t3_feat_bus_9",  32'(feat_bus), 32'h2AAAA);
        send_beat(2'd1, 1'b0);
        check("t3_err_clear",   32'(err_len), 32'h0);
        send_beat(2'd1, 1'b0);
        send_beat(2'd1, 1'b1);
        check("t3_feat_bus_12", 32'(feat_bus), 32'h2AAAA);
        check("t3_s_ready",     32'(s_ready), 32'h1);
        tick();
        tick();
        check("t3_no_result",   32'(m_valid), 32'h0);
        check("t3_no_eval",     32'(sample_count), 32'h2);

        // ---- Result back-pressure: m_ready low for 20 cycles in OUT
        cls_in  = 1'b1;
        m_ready = 1'b0;
        send_sample(18'h15555);
        tick();
        cls_in  = 1'b0;
        s_valid = 1'b1;
        s_data  = 2'd3;
        s_last  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            check("t4_stall_s_ready", 32'(s_ready), 32'h0);
            check("t4_stall_m_valid", 32'(m_valid), 32'h1);
            check("t4_stall_m_class", 32'(m_class), 32'h1);
            tick();
        end
        check("t4_stall_feat_bus", 32'(feat_bus), 32'h15555);
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        tick();
        check("t4_release_m_valid", 32'(m_valid), 32'h0);
        check("t4_release_s_ready", 32'(s_ready), 32'h1);
        check("t4_samples",         32'(sample_count), 32'h3);
        check("t4_pos",             32'(pos_count), 32'h2);

        // ---- Saturation at 2^ACC_W-1 = 15 (3 + 14 samples would be 17)
        cls_in = 1'b1;
        for (int s = 0; s < 14; s++) begin
            send_sample(18'h00000);
            tick();
            tick();
        end
        check("t5_samples_sat", 32'(sample_count), 32'hF);
        check("t5_pos_sat",     32'(pos_count), 32'hF);
        send_sample(18'h00000);
        tick();
        check("t5_samples_hold", 32'(sample_count), 32'hF);
        check("t5_pos_hold",     32'(pos_count), 32'hF);
        tick();
        // Clear coinciding with the EVAL increment
        send_sample(18'h00003);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("t5_clr_samples", 32'(sample_count), 32'h0);
        check("t5_clr_pos",     32'(pos_count), 32'h0);
        check("t5_clr_m_valid", 32'(m_valid), 32'h1);
        tick();

        // ---- Asynchronous reset mid-sample
        send_sample(18'h3FFFF);
        tick();
        check("t6_pre_samples", 32'(sample_count), 32'h1);
        tick();
        for (int k = 0; k < 5; k++) send_beat(2'd3, 1'b0);
        rst_n = 1'b0;
        #2;
        check("t6_rst_feat_bus", 32'(feat_bus), 32'h0);
        check("t6_rst_samples",  32'(sample_count), 32'h0);
        check("t6_rst_pos",      32'(pos_count), 32'h0);
        check("t6_rst_m_valid",  32'(m_valid), 32'h0);
        check("t6_rst_err_len",  32'(err_len), 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        cls_in = 1'b0;
        send_sample(18'h00001);
        check("t6_feat_bus", 32'(feat_bus), 32'h00001);
        tick();
        check("t6_m_valid", 32'(m_valid), 32'h1);
        check("t6_m_class", 32'(m_class), 32'h0);
        check("t6_samples", 32'(sample_count), 32'h1);
        check("t6_pos",     32'(pos_count), 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
